// File: rtl/sbox_layer_sequencer.sv
// Serialises a wide state word through one shared 6-bit S-box, one cell per cycle, LSB cell first.
// Supports a combinational S-box (SBOX_LAT=0) or one with a single output register (SBOX_LAT=1).
module sbox_layer_sequencer #(
    parameter int NCELLS   = 6,
    parameter int SBOX_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NCELLS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NCELLS-1:0]   out_data,
    output logic [5:0]            sbox_x,
    output logic                  sbox_en,
    input  logic [5:0]            sbox_y,
    output logic                  busy
);

    localparam int W  = 6 * NCELLS;
    localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t         fsm;
    logic [W-1:0]   state;
    logic [CW-1:0]  ic;
    logic [CW-1:0]  wc;
    logic           pend;
    logic [CW-1:0]  ic_next;

    assign ic_next = ic + CW'(1);

    // sbox_x is registered one cycle ahead, so the next cell is fetched from state while the current one is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state     <= '0;
            ic        <= '0;
            wc        <= '0;
            pend      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sbox_x    <= '0;
            sbox_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state    <= in_data;
                        ic       <= '0;
                        wc       <= '0;
                        pend     <= 1'b0;
                        sbox_en  <= 1'b1;
                        sbox_x   <= in_data[5:0];
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        fsm      <= RUN;
                    end
                end

                RUN: begin
                    if (SBOX_LAT == 0) begin
                        state[6*ic +: 6]    <= sbox_y;
                        out_data[6*ic +: 6] <= sbox_y;
                    end else begin
                        if (pend) begin
                            state[6*wc +: 6]    <= sbox_y;
                            out_data[6*wc +: 6] <= sbox_y;
                        end
                        pend <= 1'b1;
                        wc   <= ic;
                    end

                    if (ic == LAST) begin
                        sbox_en <= 1'b0;
                        sbox_x  <= '0;
                        if (SBOX_LAT == 0) begin
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            fsm       <= DONE;
                        end else begin
                            fsm <= DRAIN;
                        end
                    end else begin
                        ic     <= ic_next;
                        sbox_x <= state[6*ic_next +: 6];
                    end
                end

                DRAIN: begin
                    state[6*wc +: 6]    <= sbox_y;
                    out_data[6*wc +: 6] <= sbox_y;
                    pend      <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                    fsm       <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end

                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Bench for sbox_layer_sequencer: one instance with a combinational S-box stub and one with a
// registered stub (both sbox_y = sbox_x ^ 6'h15), checked through an expected-result scoreboard.
module tb_sbox_layer_sequencer;

    localparam int NC = 6;
    localparam int W  = 6 * NC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           iv    [2];
    logic           ordy  [2];
    logic [W-1:0]   idata [2];
    logic           irdy  [2];
    logic           ov    [2];
    logic           sen   [2];
    logic           bsy   [2];
    logic [W-1:0]   odata [2];
    logic [5:0]     sx    [2];
    logic [5:0]     sy0;
    logic [5:0]     sy1;

    logic [W-1:0]   q0 [$];
    logic [W-1:0]   q1 [$];

    int cyc = 0;
    int acc [2];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb sy0 = sx[0] ^ 6'h15;

    always @(posedge clk) sy1 <= sx[1] ^ 6'h15;

    sbox_layer_sequencer #(.NCELLS(NC), .SBOX_LAT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (irdy[0]),
        .in_data   (idata[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .out_data  (odata[0]),
        .sbox_x    (sx[0]),
        .sbox_en   (sen[0]),
        .sbox_y    (sy0),
        .busy      (bsy[0])
    );

    sbox_layer_sequencer #(.NCELLS(NC), .SBOX_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (irdy[1]),
        .in_data   (idata[1]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .out_data  (odata[1]),
        .sbox_x    (sx[1]),
        .sbox_en   (sen[1]),
        .sbox_y    (sy1),
        .busy      (bsy[1])
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[6*i +: 6] = w[6*i +: 6] ^ 6'h15;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W-1:0] front_exp(input int d);
        if (qsize(d) == 0) return '0;
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [W-1:0] pop_exp(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic push_exp(input int d, input logic [W-1:0] e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic chk(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL d%0d_%s: observed %0h expected %0h", d, tag, obs, exp);
        end
    endtask

    // Every accepted handshake pops the scoreboard; sampled 2 time units after the falling edge
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (ov[d] && ordy[d]) begin
                n_checks++;
                assert (qsize(d) != 0) else begin
                    n_fail++;
                    $error("[TB] FAIL d%0d_spurious_out: observed out_valid with empty scoreboard, expected no output", d);
                end
                if (qsize(d) != 0) chk(d, "out_data", 64'(odata[d]), 64'(pop_exp(d)));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected run to reach $finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_in_ready",  64'(irdy[d]),  64'd0);
            chk(d, "rst_out_valid", 64'(ov[d]),    64'd0);
            chk(d, "rst_out_data",  64'(odata[d]), 64'd0);
            chk(d, "rst_sbox_x",    64'(sx[d]),    64'd0);
            chk(d, "rst_sbox_en",   64'(sen[d]),   64'd0);
            chk(d, "rst_busy",      64'(bsy[d]),   64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "post_rst_in_ready", 64'(irdy[d]), 64'd1);
            chk(d, "post_rst_busy",     64'(bsy[d]),  64'd0);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [W-1:0] w, input logic [W-1:0] e);
        int n;
        @(negedge clk);
        idata[d] = w;
        iv[d]    = 1'b1;
        n = 0;
        while (!irdy[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(d, "accept_ready", 64'(irdy[d]), 64'd1);
        @(negedge clk);
        iv[d]  = 1'b0;
        acc[d] = cyc;
        push_exp(d, e);
        for (int k = 0; k < NC; k++) begin
            chk(d, "run_sbox_en", 64'(sen[d]), 64'd1);
            chk(d, "run_sbox_x",  64'(sx[d]),  64'(w[6*k +: 6]));
            chk(d, "run_busy",    64'(bsy[d]), 64'd1);
            @(negedge clk);
        end
        chk(d, "end_sbox_en", 64'(sen[d]), 64'd0);
        chk(d, "end_sbox_x",  64'(sx[d]),  64'd0);
        chk(d, "end_busy",    64'(bsy[d]), 64'(d == 1));
    endtask

    task automatic checkOutput(input int d, input int hold);
        int n;
        n = 0;
        while (!ov[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(d, "out_valid_seen", 64'(ov[d]), 64'd1);
        chk(d, "latency", 64'(cyc - acc[d]), 64'(NC + d));
        for (int h = 0; h < hold; h++) begin
            iv[d]    = 1'b1;
            idata[d] = rnd_word();
            @(negedge clk);
            chk(d, "hold_valid",    64'(ov[d]),    64'd1);
            chk(d, "hold_data",     64'(odata[d]), 64'(front_exp(d)));
            chk(d, "hold_in_ready", 64'(irdy[d]),  64'd0);
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk(d, "post_hs_valid",    64'(ov[d]),   64'd0);
        chk(d, "post_hs_in_ready", 64'(irdy[d]), 64'd1);
        @(negedge clk);
        chk(d, "post_hs_busy",     64'(bsy[d]),  64'd0);
    endtask

    task automatic mid_reset(input int d);
        logic [W-1:0] w;
        @(negedge clk);
        idata[d] = 36'h123456789;
        iv[d]    = 1'b1;
        chk(d, "mr_in_ready", 64'(irdy[d]), 64'd1);
        @(negedge clk);
        iv[d] = 1'b0;
        repeat (3) @(negedge clk);
        chk(d, "mr_busy_before", 64'(bsy[d]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk(d, "mr_out_valid", 64'(ov[d]),    64'd0);
        chk(d, "mr_busy",      64'(bsy[d]),   64'd0);
        chk(d, "mr_sbox_en",   64'(sen[d]),   64'd0);
        chk(d, "mr_sbox_x",    64'(sx[d]),    64'd0);
        chk(d, "mr_out_data",  64'(odata[d]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        w = 36'h0F0F0F0F0;
        applyStimulus(d, w, model(w));
        checkOutput(d, 0);
    endtask

    task automatic back_to_back(input int d);
        logic [W-1:0] words [4];
        int at [4];
        int n;
        for (int k = 0; k < 4; k++) words[k] = rnd_word();
        ordy[d]  = 1'b1;
        idata[d] = words[0];
        iv[d]    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!irdy[d] && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk(d, "b2b_ready", 64'(irdy[d]), 64'd1);
            @(negedge clk);
            at[k] = cyc;
            push_exp(d, model(words[k]));
            if (k < 3) idata[d] = words[k+1];
            else iv[d] = 1'b0;
        end
        for (int k = 0; k < 3; k++) chk(d, "b2b_spacing", 64'(at[k+1] - at[k]), 64'(NC + d + 2));
        repeat (NC + d + 4) @(negedge clk);
        ordy[d] = 1'b0;
        chk(d, "b2b_drained", 64'(qsize(d)), 64'd0);
    endtask

    initial begin
        logic [5:0]   v6;
        logic [W-1:0] w;
        for (int d = 0; d < 2; d++) begin
            iv[d]    = 1'b0;
            ordy[d]  = 1'b0;
            idata[d] = '0;
        end
        do_reset();

        applyStimulus(0, 36'h000000000, 36'h555555555);
        checkOutput(0, 0);
        applyStimulus(1, 36'hFFFFFFFFF, 36'hAAAAAAAAA);
        checkOutput(1, 0);

        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 36'h000000FC0, 36'h555555A95);
            checkOutput(d, 10);
        end

        for (int d = 0; d < 2; d++) mid_reset(d);

        for (int d = 0; d < 2; d++) back_to_back(d);

        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 64; v++) begin
                v6 = 6'(v);
                applyStimulus(d, {6{v6}}, {6{v6 ^ 6'h15}});
                checkOutput(d, 0);
            end
            for (int k = 0; k < 6; k++) begin
                w = rnd_word();
                applyStimulus(d, w, model(w));
                checkOutput(d, 0);
            end
        end

        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) chk(d, "scoreboard_drained", 64'(qsize(d)), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
